// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared LEGv8 core types, widths and branch-target helper
//
// Purpose : common definitions for the fetch stage and its FIFO.
//   ADDR_W / INSTR_W : PC and instruction widths.
//   fetch_entry_t    : {pc, instr} pair carried from fetch to decode.
//   br_target()      : B / CBZ / B.cond target = pc + (sext(imm) << 2), mod 2^64.
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // uncond=1 selects B imm26 = instr[25:0]; uncond=0 selects imm19 = instr[23:5].
    // The shift by 2 is folded into the concatenation so the offset is already 64 bits.
    function automatic logic [ADDR_W-1:0] br_target(
        input logic [ADDR_W-1:0]  pc,
        input logic [INSTR_W-1:0] instr,
        input logic               uncond
    );
        logic [ADDR_W-1:0] offset;
        if (uncond) begin
            offset = {{36{instr[25]}}, instr[25:0], 2'b00};
        end else begin
            offset = {{43{instr[23]}}, instr[23:5], 2'b00};
        end
        return pc + offset;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// rtl/instr_fetch_unit_fifo.sv - fetch FIFO holding {pc, instr} entries
//
// Purpose : DEPTH-entry circular buffer between the PC/imem side and decode.
// Ports   :
//   clk, reset      clock, asynchronous active-high reset
//   push, wdata     write wdata at the tail
//   pop             retire the head entry
//   flush           empty the FIFO; takes priority over push and pop
//   head            entry at the read pointer (undefined when count == 0)
//   count           occupancy, 0..DEPTH
//   full            count == DEPTH
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    // Pointers are log2(DEPTH) bits, so they wrap without explicit compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == FULL_CNT);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - LEGv8 fetch stage: PC, imem address, fetch FIFO, redirect
//
// Purpose : owns the PC, fetches one instruction per cycle into fetch_fifo and
//           presents the head to decode with a valid/ready handshake. A taken
//           branch (br_taken) loads the computed target and flushes the FIFO.
// Ports   :
//   clk, reset                 clock, asynchronous active-high reset
//   imem_addr / imem_rdata     instruction memory address (= PC) and returned word
//   if_valid/if_ready          head handshake to decode
//   if_instr/if_pc             head entry, forced to 0 while if_valid is low
//   br_taken                   redirect request this cycle
//   uncond_br                  1: B imm26, 0: CBZ/B.cond imm19
//   br_instr/br_pc             branch being resolved and its PC
//   stat_fetched/stat_redirects  push and redirect counters (IFETCH_STATS_EN only)
// Build option : define IFETCH_STATS_EN to add the statistics counters.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    input  logic                br_taken,
    input  logic                uncond_br,
    input  logic [INSTR_W-1:0]  br_instr,
    input  logic [ADDR_W-1:0]   br_pc
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]         stat_fetched,
    output logic [31:0]         stat_redirects
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic [AW:0]       fifo_count;
    fetch_entry_t      fifo_head;
    fetch_entry_t      fifo_wdata;

    assign redirect = br_taken;
    assign pop      = if_valid & if_ready;
    // A full FIFO can still accept when decode pops the head in the same cycle.
    assign push     = !redirect & (!fifo_full | pop);

    assign fifo_wdata.pc    = pc;
    assign fifo_wdata.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full)
    );

    assign imem_addr = pc;
    assign if_valid  = (fifo_count != '0);
    assign if_instr  = if_valid ? fifo_head.instr : '0;
    assign if_pc     = if_valid ? fifo_head.pc    : '0;

    // Next PC: redirect target, else sequential when an entry was pushed, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= br_target(br_pc, br_instr, uncond_br);
        end else if (push) begin
            pc <= pc + 64'd4;
        end
    end

`ifdef IFETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched   <= '0;
            stat_redirects <= '0;
        end else begin
            if (push) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (redirect) begin
                stat_redirects <= stat_redirects + 32'd1;
            end
        end
    end
`endif

endmodule
